// File: rtl/async_rptr_status.sv
// -----------------------------------------------------------------------------
// async_rptr_status
//   Read-domain pointer and status logic for a dual-clock FIFO. It brings the
//   gray-coded write pointer into the rclk domain, decodes it to binary, and
//   keeps the read pointer. All status outputs are registered: empty,
//   almost_empty, occupancy count and a sticky underflow flag.
//
// Parameters
//   ADDR_WIDTH   RAM address bits; DEPTH = 2**ADDR_WIDTH; pointers ADDR_WIDTH+1
//   SYNC_STAGES  flops in the write-pointer synchronizer (>= 2)
//   AE_THRESH    almost_empty asserted when occupancy <= AE_THRESH (< DEPTH)
//
// Ports
//   rclk          read clock
//   rrst          asynchronous reset, active-high
//   r_en          read request, accepted only while !empty
//   w_ptr_gray    gray write pointer from the wclk domain (asynchronous)
//   uf_clr        clear sticky underflow
//   r_ptr         registered gray read pointer, to the write-side synchronizer
//   r_addr        RAM read address (low bits of the binary read pointer)
//   empty         registered empty flag
//   almost_empty  registered, occupancy <= AE_THRESH
//   r_count       registered occupancy, 0..DEPTH
//   underflow     sticky, set by a read attempted while empty
// -----------------------------------------------------------------------------
module async_rptr_status #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH:0]   w_ptr_gray,
  input  logic                  uf_clr,
  output logic [ADDR_WIDTH:0]   r_ptr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   r_count,
  output logic                  underflow
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [AW:0] AE_LIMIT = AE_THRESH[AW:0];

  // Parameter legality checks at elaboration time.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("async_rptr_status: SYNC_STAGES must be >= 2");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
      $error("async_rptr_status: AE_THRESH must be < DEPTH");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write-pointer synchronizer: a plain flop chain, nothing between stages.
  // ---------------------------------------------------------------------------
  logic [AW:0] sync_reg [SYNC_STAGES];
  logic [AW:0] rg_wptr;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
    end else begin
      sync_reg[0] <= w_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign rg_wptr = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Gray -> binary: each binary bit is the XOR of all gray bits at or above it.
  // Written as independent reductions so no bit depends on another bit.
  // ---------------------------------------------------------------------------
  logic [AW:0] wbin;

  generate
    for (genvar gi = 0; gi <= AW; gi++) begin : g_g2b
      assign wbin[gi] = ^rg_wptr[AW:gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read pointer and status
  // ---------------------------------------------------------------------------
  logic [AW:0] rbin_reg;
  logic [AW:0] rbin_next;
  logic [AW:0] r_ptr_reg;
  logic [AW:0] r_ptr_next;
  logic [AW:0] cnt_next;
  logic        empty_reg;
  logic        empty_next;
  logic        ae_reg;
  logic        ae_next;
  logic [AW:0] count_reg;
  logic        uf_reg;
  logic        uf_next;
  logic        accept;

  assign accept     = r_en & ~empty_reg;
  assign rbin_next  = rbin_reg + {{AW{1'b0}}, accept};
  assign r_ptr_next = (rbin_next >> 1) ^ rbin_next;

  // Status is computed from the post-read pointer so an accepted read is
  // reflected in the same edge that accepts it.
  assign empty_next = (r_ptr_next == rg_wptr);
  assign cnt_next   = wbin - rbin_next;   // modulo 2**(AW+1), wrap-safe
  assign ae_next    = (cnt_next <= AE_LIMIT);

  // Set has priority over clear so a simultaneous underflow is never lost.
  always_comb begin
    uf_next = uf_reg;
    if (uf_clr) begin
      uf_next = 1'b0;
    end
    if (r_en && empty_reg) begin
      uf_next = 1'b1;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_reg  <= '0;
      r_ptr_reg <= '0;
      empty_reg <= 1'b1;
      ae_reg    <= 1'b1;
      count_reg <= '0;
      uf_reg    <= 1'b0;
    end else begin
      rbin_reg  <= rbin_next;
      r_ptr_reg <= r_ptr_next;
      empty_reg <= empty_next;
      ae_reg    <= ae_next;
      count_reg <= cnt_next;
      uf_reg    <= uf_next;
    end
  end

  assign r_ptr        = r_ptr_reg;
  assign r_addr       = rbin_reg[AW-1:0];
  assign empty        = empty_reg;
  assign almost_empty = ae_reg;
  assign r_count      = count_reg;
  assign underflow    = uf_reg;

endmodule

// File: tb/tb_async_rptr_status.sv
module tb_async_rptr_status;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       r_en;
  logic [4:0] w_ptr_gray;
  logic       uf_clr;
  logic [4:0] r_ptr;
  logic [3:0] r_addr;
  logic       empty;
  logic       almost_empty;
  logic [4:0] r_count;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  async_rptr_status #(
    .ADDR_WIDTH (4),
    .SYNC_STAGES(2),
    .AE_THRESH  (2)
  ) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .r_en        (r_en),
    .w_ptr_gray  (w_ptr_gray),
    .uf_clr      (uf_clr),
    .r_ptr       (r_ptr),
    .r_addr      (r_addr),
    .empty       (empty),
    .almost_empty(almost_empty),
    .r_count     (r_count),
    .underflow   (underflow)
  );

  always #5 rclk = ~rclk;

  // Advance one edge; outputs are sampled and inputs driven 1ns after it.
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = b[4:0];
    return (v >> 1) ^ v;
  endfunction

  task automatic test_reset();
    rrst = 1'b1;
    w_ptr_gray = 5'b00011;
    uf_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_en = i[0];
      tick();
      n_checks++;
      if ({empty, almost_empty, r_count, r_ptr, underflow} !== {1'b1, 1'b1, 5'd0, 5'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: empty=%b ae=%b cnt=%0d rptr=%b uf=%b, want 1 1 0 00000 0",
                 i, empty, almost_empty, r_count, r_ptr, underflow);
      end
    end
    r_en = 1'b0;
    w_ptr_gray = 5'b00000;
    rrst = 1'b0;
    tick();
    n_checks++;
    if (r_addr !== 4'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: r_addr=%0d empty=%b, want 0 1", r_addr, empty);
    end
    $display("test_reset done");
  endtask

  task automatic test_sync_latency();
    w_ptr_gray = 5'b00001;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (e < 3) begin
        if (empty !== 1'b1 || r_count !== 5'd0) begin
          n_fail++;
          $display("FAIL sync_early edge%0d: empty=%b cnt=%0d, want 1 0", e, empty, r_count);
        end
      end else begin
        if (empty !== 1'b0 || r_count !== 5'd1 || almost_empty !== 1'b1) begin
          n_fail++;
          $display("FAIL sync_edge3: empty=%b cnt=%0d ae=%b, want 0 1 1", empty, r_count, almost_empty);
        end
      end
    end
    $display("test_sync_latency done");
  endtask

  task automatic test_drain();
    w_ptr_gray = 5'b00010;   // three words written
    repeat (3) tick();
    n_checks++;
    if (r_count !== 5'd3 || empty !== 1'b0 || almost_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_fill: cnt=%0d empty=%b ae=%b, want 3 0 0", r_count, empty, almost_empty);
    end
    r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_addr !== i[3:0]) begin
        n_fail++;
        $display("FAIL drain_addr[%0d]: r_addr=%0d, want %0d", i, r_addr, i);
      end
      tick();
      n_checks++;
      if (r_count !== 5'(2 - i) || empty !== (i == 2) || underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_read[%0d]: cnt=%0d empty=%b uf=%b, want %0d %b 0",
                 i, r_count, empty, underflow, 2 - i, (i == 2));
      end
    end
    tick();   // 4th read, FIFO empty
    n_checks++;
    if (underflow !== 1'b1 || r_addr !== 4'd3 || r_count !== 5'd0 || r_ptr !== 5'b00010) begin
      n_fail++;
      $display("FAIL drain_underflow: uf=%b addr=%0d cnt=%0d rptr=%b, want 1 3 0 00010",
               underflow, r_addr, r_count, r_ptr);
    end
    r_en = 1'b0;
    $display("test_drain done");
  endtask

  task automatic test_underflow_clear();
    uf_clr = 1'b1;
    tick();
    n_checks++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_clear: uf=%b, want 0", underflow);
    end
    r_en = 1'b1;   // set and clear together while empty
    tick();
    n_checks++;
    if (underflow !== 1'b1 || r_addr !== 4'd3) begin
      n_fail++;
      $display("FAIL uf_set_wins: uf=%b addr=%0d, want 1 3", underflow, r_addr);
    end
    r_en = 1'b0;
    tick();
    r_en = 1'b0;
    uf_clr = 1'b0;
    n_checks++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_reclear: uf=%b, want 0", underflow);
    end
    $display("test_underflow_clear done");
  endtask

  task automatic test_wrap_full();
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    w_ptr_gray = 5'b11000;   // write pointer = 16: full
    repeat (3) tick();
    n_checks++;
    if (r_count !== 5'd16 || almost_empty !== 1'b0 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL full: cnt=%0d ae=%b empty=%b, want 16 0 0", r_count, almost_empty, empty);
    end
    r_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_checks++;
      if (r_count !== 5'(16 - i) || r_ptr !== gray5(i) || almost_empty !== (16 - i <= 2)) begin
        n_fail++;
        $display("FAIL wrap_read1[%0d]: cnt=%0d rptr=%b ae=%b, want %0d %b %b",
                 i, r_count, r_ptr, almost_empty, 16 - i, gray5(i), (16 - i <= 2));
      end
    end
    r_en = 1'b0;
    n_checks++;
    if (r_ptr !== 5'b11000 || empty !== 1'b1 || r_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_half: rptr=%b empty=%b addr=%0d, want 11000 1 0", r_ptr, empty, r_addr);
    end
    w_ptr_gray = 5'b00000;   // 16 more written: write pointer 32 -> 0
    repeat (3) tick();
    n_checks++;
    if (r_count !== 5'd16 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_refill: cnt=%0d empty=%b, want 16 0", r_count, empty);
    end
    r_en = 1'b1;
    for (int i = 17; i <= 32; i++) begin
      tick();
      n_checks++;
      if (r_count !== 5'(32 - i) || r_ptr !== gray5(i)) begin
        n_fail++;
        $display("FAIL wrap_read2[%0d]: cnt=%0d rptr=%b, want %0d %b",
                 i, r_count, r_ptr, 32 - i, gray5(i));
      end
    end
    r_en = 1'b0;
    n_checks++;
    if (r_ptr !== 5'b00000 || empty !== 1'b1 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done: rptr=%b empty=%b uf=%b, want 00000 1 0", r_ptr, empty, underflow);
    end
    $display("test_wrap_full done");
  endtask

  task automatic test_reset_mid_drain();
    w_ptr_gray = 5'b00100;   // write pointer = 7
    repeat (3) tick();
    r_en = 1'b1;
    n_checks++;
    if (r_count !== 5'd7 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fill: cnt=%0d empty=%b, want 7 0", r_count, empty);
    end
    rrst = 1'b1;   // asynchronous: effective before any edge
    #1;
    n_checks++;
    if ({empty, almost_empty, r_count, r_ptr, r_addr, underflow} !==
        {1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: empty=%b ae=%b cnt=%0d rptr=%b addr=%0d uf=%b, want 1 1 0 00000 0 0",
               empty, almost_empty, r_count, r_ptr, r_addr, underflow);
    end
    r_en = 1'b0;
    tick();
    rrst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (e < 3 && (empty !== 1'b1 || r_count !== 5'd0)) begin
        n_fail++;
        $display("FAIL mid_release edge%0d: empty=%b cnt=%0d, want 1 0", e, empty, r_count);
      end else if (e == 3 && (empty !== 1'b0 || r_count !== 5'd7)) begin
        n_fail++;
        $display("FAIL mid_release edge3: empty=%b cnt=%0d, want 0 7", empty, r_count);
      end
    end
    $display("test_reset_mid_drain done");
  endtask

  initial begin
    rrst = 1'b1;
    r_en = 1'b0;
    uf_clr = 1'b0;
    w_ptr_gray = 5'b00000;
    test_reset();
    test_sync_latency();
    test_drain();
    test_underflow_clear();
    test_wrap_full();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
